// File: rtl/stage_fetch.sv
// stage_fetch: instruction-fetch stage feeding stage_decode.
// Holds the fetch PC, issues single-outstanding requests to the instruction
// memory and registers each returned word with its PC into the IF/ID output.
// A decode stall holds the output and parks at most one in-flight response
// in a 1-entry skid. A redirect from execute flushes the output to a zero
// bubble and restarts fetching at the redirect target.
// Optional feature: define FETCH_PERF_CNT_EN to add the saturating
// perf_fetched_o / perf_bubble_o event counters.
module stage_fetch #(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        DATA_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int unsigned        PC_INC   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [DATA_W-1:0] imem_rdata_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] instr_o,
    output logic              instr_valid_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched_o,
    output logic [31:0]       perf_bubble_o
`endif
);

    // IDLE:  one settling cycle after reset release.
    // REQ:   request pending (or waiting for room to raise it).
    // WAIT:  one request granted, response outstanding.
    // DRAIN: outstanding response belongs to a flushed path; discard it.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   fetch_pc, fetch_pc_nxt;
    logic [ADDR_W-1:0]   pc_inc;
    logic                req_held, req_held_nxt;
    logic                can_issue;
    logic                resp_take;

    logic                skid_valid;
    logic [ADDR_W-1:0]   skid_pc;
    logic [DATA_W-1:0]   skid_data;

    logic                out_load_valid;

    // Address of the word after the one currently being fetched; wraps
    // modulo 2^ADDR_W by construction of the fixed-width add.
    assign pc_inc = fetch_pc + ADDR_W'(PC_INC);

    // A fresh request may only be raised when the response has somewhere to
    // go: decode is not stalled and the skid is free.
    assign can_issue = !stall_i && !skid_valid;

    // A response is kept only on the live path (WAIT) and not when a
    // redirect squashes it in the same cycle.
    assign resp_take = (state == S_WAIT) && imem_rvalid_i && !redirect_i;

    // State register and fetch PC, synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block order.
        if (!reset_n) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            req_held <= 1'b0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            req_held <= req_held_nxt;
        end
    end

    // Next-state logic and memory request outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        req_held_nxt = 1'b0;
        imem_req_o   = 1'b0;
        imem_addr_o  = fetch_pc;

        case (state)
            S_IDLE: begin
                state_nxt = S_REQ;
                if (redirect_i) begin
                    fetch_pc_nxt = redirect_pc_i;
                end
            end

            S_REQ: begin
                if (redirect_i) begin
                    // Withdraw this cycle; re-raise next cycle at the target.
                    fetch_pc_nxt = redirect_pc_i;
                end else begin
                    // Once raised, the request stays up until granted even
                    // if a stall arrives meanwhile.
                    imem_req_o = req_held || can_issue;
                    if (imem_req_o) begin
                        if (imem_gnt_i) begin
                            state_nxt = S_WAIT;
                        end else begin
                            req_held_nxt = 1'b1;
                        end
                    end
                end
            end

            S_WAIT: begin
                if (redirect_i) begin
                    fetch_pc_nxt = redirect_pc_i;
                    // With the response here it is simply dropped; otherwise
                    // it is still owed and must be drained first.
                    state_nxt = imem_rvalid_i ? S_REQ : S_DRAIN;
                end else if (imem_rvalid_i) begin
                    fetch_pc_nxt = pc_inc;
                    // Back-to-back issue of the next address in the
                    // response cycle keeps the single-outstanding rule.
                    imem_addr_o = pc_inc;
                    imem_req_o  = can_issue;
                    if (imem_req_o && imem_gnt_i) begin
                        state_nxt = S_WAIT;
                    end else begin
                        state_nxt    = S_REQ;
                        req_held_nxt = imem_req_o;
                    end
                end
            end

            S_DRAIN: begin
                // The latest redirect target wins.
                if (redirect_i) begin
                    fetch_pc_nxt = redirect_pc_i;
                end
                if (imem_rvalid_i) begin
                    state_nxt = S_REQ;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // IF/ID output register and skid occupancy.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_o          <= '0;
            instr_o       <= '0;
            instr_valid_o <= 1'b0;
            skid_valid    <= 1'b0;
        end else if (redirect_i) begin
            // Flush beats stall: decode must never see a wrong-path word.
            instr_o       <= '0;
            instr_valid_o <= 1'b0;
            skid_valid    <= 1'b0;
        end else if (!stall_i) begin
            if (skid_valid) begin
                // The parked word is older than anything in flight.
                pc_o          <= skid_pc;
                instr_o       <= skid_data;
                instr_valid_o <= 1'b1;
                skid_valid    <= 1'b0;
            end else if (resp_take) begin
                pc_o          <= fetch_pc;
                instr_o       <= imem_rdata_i;
                instr_valid_o <= 1'b1;
            end else begin
                instr_o       <= '0;
                instr_valid_o <= 1'b0;
            end
        end else if (resp_take) begin
            skid_valid <= 1'b1;
        end
    end

    // Skid payload, written when a response lands during a stall.
    always_ff @(posedge clk) begin
        // NOTE: the payload has no reset; skid_valid qualifies it and is
        // itself reset, so stale contents can never be presented.
        if (reset_n && !redirect_i && stall_i && resp_take) begin
            skid_pc   <= fetch_pc;
            skid_data <= imem_rdata_i;
        end
    end

    // The output register takes a real instruction at the next edge.
    assign out_load_valid = !redirect_i && !stall_i && (skid_valid || resp_take);

`ifdef FETCH_PERF_CNT_EN
    logic bubble_evt;

    // Bubble: the output goes (or stays) empty while decode is not stalled.
    assign bubble_evt = !stall_i && !out_load_valid;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_fetched_o <= '0;
            perf_bubble_o  <= '0;
        end else begin
            if (out_load_valid && (perf_fetched_o != 32'hFFFF_FFFF)) begin
                perf_fetched_o <= perf_fetched_o + 32'd1;
            end
            if (bubble_evt && (perf_bubble_o != 32'hFFFF_FFFF)) begin
                perf_bubble_o <= perf_bubble_o + 32'd1;
            end
        end
    end
`else
    logic unused_load;
    assign unused_load = out_load_valid;
`endif

endmodule

// File: tb/tb_stage_fetch.sv
// Self-checking bench for stage_fetch. A behavioural instruction memory
// answers requests with address-tagged words; the stimulus side keeps a
// queue of the program-order PCs decode should see, and a monitor pops and
// compares every instruction the DUT presents. A second instance with a
// wrapping RESET_PC checks the start-up address sequence.
module tb_stage_fetch;

    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, stall_i, redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i, imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc_o, instr_o;
    logic        instr_valid_o;

    logic        w_stall, w_redirect, w_req, w_gnt, w_rvalid, w_valid;
    logic [31:0] w_redirect_pc, w_addr, w_rdata, w_pc, w_instr;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_o, perf_bubble_o, w_perf_fetched, w_perf_bubble;
`endif

    stage_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset_n(reset_n), .stall_i(stall_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i(imem_rdata_i),
        .pc_o(pc_o), .instr_o(instr_o), .instr_valid_o(instr_valid_o)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched_o(perf_fetched_o), .perf_bubble_o(perf_bubble_o)
`endif
    );

    stage_fetch #(.RESET_PC(WRAP_PC)) u_wrap (
        .clk(clk), .reset_n(reset_n), .stall_i(w_stall),
        .redirect_i(w_redirect), .redirect_pc_i(w_redirect_pc),
        .imem_req_o(w_req), .imem_addr_o(w_addr),
        .imem_gnt_i(w_gnt), .imem_rvalid_i(w_rvalid),
        .imem_rdata_i(w_rdata),
        .pc_o(w_pc), .instr_o(w_instr), .instr_valid_o(w_valid)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched_o(w_perf_fetched), .perf_bubble_o(w_perf_bubble)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory content: a tag derived from the address, never zero for
    // word-aligned addresses.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // Memory model and scoreboard state (stimulus side).
    bit          mem_busy = 0;
    logic [31:0] mem_addr;
    int unsigned mem_cnt;
    int unsigned lat_min = 0, lat_max = 0, gnt_pct = 100;
    logic [31:0] exp_q[$];
    logic [31:0] next_pc;
    bit          exp_addr_pend = 0;
    logic [31:0] exp_addr;
    bit          prev_pending = 0;
    logic [31:0] prev_addr;
    bit          steady_chk = 0;
    bit          w_busy = 0;
    logic [31:0] w_lat_addr;

    // One clock cycle of stimulus: drive at the falling edge, then resolve
    // the grant once the request outputs have settled.
    task automatic drive_cycle(input bit rst, input bit stall, input bit redir, input logic [31:0] tgt);
        bit gnt;
        @(negedge clk);
        reset_n       = !rst;
        stall_i       = stall;
        redirect_i    = redir;
        redirect_pc_i = tgt;

        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        if (rst) begin
            mem_busy = 0;
        end else if (mem_busy) begin
            if (mem_cnt == 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = word_of(mem_addr);
                mem_busy      = 0;
            end else begin
                mem_cnt--;
            end
        end

        w_rvalid = !rst && w_busy;
        w_rdata  = word_of(w_lat_addr);
        w_busy   = 0;

        // Reference: decode sees consecutive PCs from the start address,
        // restarting at the target on every flush.
        if (rst) begin
            exp_q.delete();
            next_pc       = RST_PC;
            exp_addr_pend = 1;
            exp_addr      = RST_PC;
        end else if (redir) begin
            exp_q.delete();
            next_pc       = tgt;
            exp_addr_pend = 1;
            exp_addr      = tgt;
        end
        while (exp_q.size() < 4) begin
            exp_q.push_back(next_pc);
            next_pc = next_pc + 32'd4;
        end

        #1;
        gnt = !rst && imem_req_o && ($urandom_range(99) < gnt_pct);
        imem_gnt_i = gnt;
        if (!rst) begin
            if (redir) check("req_withdrawn_on_redirect", imem_req_o, 0);
            if (prev_pending && !redir) begin
                check("req_held_until_gnt", imem_req_o, 1);
                check("addr_held_until_gnt", imem_addr_o, prev_addr);
            end else if (stall) begin
                check("no_new_req_in_stall", imem_req_o, 0);
            end
            if (gnt) begin
                if (exp_addr_pend) begin
                    check("first_addr_after_flush", imem_addr_o, exp_addr);
                    exp_addr_pend = 0;
                end
                check("single_outstanding", mem_busy, 0);
                mem_busy = 1;
                mem_addr = imem_addr_o;
                mem_cnt  = $urandom_range(lat_max, lat_min);
            end
            if (w_req) begin
                w_busy     = 1;
                w_lat_addr = w_addr;
            end
        end
        prev_pending = !rst && imem_req_o && !gnt && !redir;
        prev_addr    = imem_addr_o;
    endtask

    // Monitor: after each rising edge, classify what the output register
    // should have done and pop the scoreboard for every new instruction.
    bit          rst_e, st_e, rd_e;
    logic [31:0] prev_pc = 0, prev_instr = 0;
    logic        prev_valid = 0;
    logic [31:0] e_pc;
    int          n_valid = 0;
    int          idle_cnt = 0;
    int          w_cnt = 0;
    logic [31:0] wrap_exp [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] exp_fetched = 0, exp_bubble = 0;
`endif

    always @(posedge clk) begin
        rst_e = !reset_n;
        st_e  = stall_i;
        rd_e  = redirect_i;
        #1;
        if (rst_e) begin
            check("reset_pc_o", pc_o, 0);
            check("reset_instr_o", instr_o, 0);
            check("reset_valid", instr_valid_o, 0);
            check("reset_req", imem_req_o, 0);
            check("reset_addr", imem_addr_o, RST_PC);
            idle_cnt = 0;
`ifdef FETCH_PERF_CNT_EN
            check("reset_perf_fetched", perf_fetched_o, 0);
            check("reset_perf_bubble", perf_bubble_o, 0);
            exp_fetched = 0;
            exp_bubble  = 0;
`endif
        end else begin
            if (rd_e) begin
                check("flush_instr", instr_o, 0);
                check("flush_valid", instr_valid_o, 0);
            end else if (st_e) begin
                check("stall_hold_pc", pc_o, prev_pc);
                check("stall_hold_instr", instr_o, prev_instr);
                check("stall_hold_valid", instr_valid_o, prev_valid);
            end else if (instr_valid_o) begin
                e_pc = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
                check("pc_order", pc_o, e_pc);
                check("instr_data", instr_o, word_of(e_pc));
                n_valid++;
            end else begin
                check("bubble_instr", instr_o, 0);
                check("bubble_pc_hold", pc_o, prev_pc);
            end
            if (steady_chk && prev_valid && !st_e && !rd_e)
                check("steady_valid", instr_valid_o, 1);

            if (!rd_e && !st_e && instr_valid_o) idle_cnt = 0;
            else idle_cnt++;
            if (idle_cnt == 150) begin
                check("fetch_progress", idle_cnt, 0);
                idle_cnt = 0;
            end
`ifdef FETCH_PERF_CNT_EN
            if (!rd_e && !st_e && instr_valid_o) exp_fetched++;
            if (!st_e && !instr_valid_o) exp_bubble++;
            check("perf_fetched", perf_fetched_o, exp_fetched);
            check("perf_bubble", perf_bubble_o, exp_bubble);
`endif
            if (w_valid && w_cnt < 3) begin
                check("wrap_pc", w_pc, wrap_exp[w_cnt]);
                check("wrap_instr", w_instr, word_of(wrap_exp[w_cnt]));
                w_cnt++;
            end
        end
        prev_pc    = pc_o;
        prev_instr = instr_o;
        prev_valid = instr_valid_o;
    end

    initial begin
        bit          st, rd;
        logic [31:0] tgt;
        reset_n = 0; stall_i = 0; redirect_i = 0; redirect_pc_i = 0;
        imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
        w_stall = 0; w_redirect = 0; w_redirect_pc = 0; w_gnt = 1;
        w_rvalid = 0; w_rdata = 0; w_lat_addr = 0;

        // Reset, then same-cycle grant / next-cycle response: 1 instr/cycle.
        repeat (3) drive_cycle(1, 0, 0, 0);
        steady_chk = 1;
        repeat (14) drive_cycle(0, 0, 0, 0);
        steady_chk = 0;

        // Three-cycle stall with a word in flight.
        repeat (3) drive_cycle(0, 1, 0, 0);
        repeat (10) drive_cycle(0, 0, 0, 0);

        // Redirect while a response is outstanding two cycles out.
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 20 && !mem_busy; i++) drive_cycle(0, 0, 0, 0);
        check("wait_reached_before_redirect", mem_busy, 1);
        drive_cycle(0, 0, 1, 32'h0000_0100);
        repeat (12) drive_cycle(0, 0, 0, 0);

        // Redirect together with stall, then stall a little longer.
        lat_min = 0; lat_max = 0;
        drive_cycle(0, 1, 1, 32'h0000_0200);
        repeat (2) drive_cycle(0, 1, 0, 0);
        repeat (10) drive_cycle(0, 0, 0, 0);

        // Fetch across the top of the address space.
        drive_cycle(0, 0, 1, 32'hFFFF_FFF0);
        repeat (10) drive_cycle(0, 0, 0, 0);

        // Randomized traffic: grant delay, response latency, stall, redirect.
        gnt_pct = 60; lat_min = 0; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            st = ($urandom_range(99) < 25);
            rd = ($urandom_range(99) < 3);
            if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 + {28'h0, 2'($urandom_range(3)), 2'b00};
            else tgt = {20'h0, 10'($urandom_range(1023)), 2'b00};
            drive_cycle(0, st, rd, tgt);
        end

        // Reset while a response is outstanding, then resume.
        gnt_pct = 100; lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && !mem_busy; i++) drive_cycle(0, 0, 0, 0);
        check("wait_reached_before_reset", mem_busy, 1);
        drive_cycle(0, 0, 0, 0);
        repeat (2) drive_cycle(1, 0, 0, 0);
        lat_min = 0; lat_max = 0;
        repeat (12) drive_cycle(0, 0, 0, 0);

        check("enough_instructions_seen", (n_valid > 200) ? 32'd1 : 32'd0, 1);
        check("wrap_sequence_seen", w_cnt, 3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
